// File: rtl/dlx_pkg.sv
// Shared opcodes, instruction field positions and the ID/EX control record for the DLX decode stage.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_LD_LO = 6'h20;
  localparam logic [5:0] OP_LD_HI = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB   = 31, OP_LSB   = 26;
  localparam int RS1_MSB  = 25, RS1_LSB  = 21;
  localparam int RS2_MSB  = 20, RS2_LSB  = 16;
  localparam int RDR_MSB  = 15, RDR_LSB  = 11;
  localparam int RDI_MSB  = 20, RDI_LSB  = 16;
  localparam int FUNC_MSB = 5,  FUNC_LSB = 0;
  localparam int IMM_MSB  = 15, JOFF_MSB = 25;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Operands live outside this record so their width can follow XLEN.
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
    logic        load;
  } idex_t;

endpackage

// File: rtl/dlx_hazard.sv
// Operand bypass selection and decode stall generation.
// DLX_FWD_EN enables the MEM-stage bypass; without it any pending write to a read source stalls.
module dlx_hazard #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic            use_rs2_i,
  input  logic [XLEN-1:0] s1_i,
  input  logic [XLEN-1:0] s2_i,
  input  logic            mem_wen_i,
  input  logic [4:0]      mem_rd_i,
  input  logic [XLEN-1:0] mem_res_i,
  input  logic            wb_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            id_valid_i,
  input  logic            id_load_i,
  input  logic            id_wen_i,
  input  logic [4:0]      id_rd_i,
  output logic [XLEN-1:0] op_a_o,
  output logic [XLEN-1:0] op_b_o,
  output logic            stall_o
);

  logic [1:0][4:0]      src;
  logic [1:0][XLEN-1:0] rf;
  logic [1:0][XLEN-1:0] op;

  assign src = {rs2_i, rs1_i};
  assign rf  = {s2_i, s1_i};

  // Later assignments win, so the order below is lowest to highest priority.
  always_comb begin
    op = rf;
    for (int i = 0; i < 2; i++) begin
      if (wb_i && wb_rd_i == src[i]) op[i] = wb_data_i;
`ifdef DLX_FWD_EN
      if (mem_wen_i && mem_rd_i == src[i]) op[i] = mem_res_i;
`endif
      if (src[i] == 5'd0) op[i] = '0;
    end
  end

  assign op_a_o = op[0];
  assign op_b_o = op[1];

`ifdef DLX_FWD_EN
  assign stall_o = id_valid_i && id_load_i && id_wen_i &&
                   (id_rd_i == rs1_i || (use_rs2_i && id_rd_i == rs2_i));
`else
  logic [1:0] pend;
  logic       unused_fwd;

  always_comb begin
    pend = '0;
    for (int i = 0; i < 2; i++)
      pend[i] = src[i] != 5'd0 &&
                ((id_valid_i && id_wen_i && id_rd_i == src[i]) ||
                 (mem_wen_i && mem_rd_i == src[i]));
  end

  assign stall_o    = pend[0] || (use_rs2_i && pend[1]);
  assign unused_fwd = ^{mem_res_i, id_load_i};
`endif

endmodule

// File: rtl/dlx_decode.sv
// DLX decode stage: field split, immediate/rd/write-enable decode and the ID/EX register.
// Build option DLX_FWD_EN selects MEM-stage bypassing (see dlx_hazard).
module dlx_decode
  import dlx_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  output logic            id_ready,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  input  logic [XLEN-1:0] S1,
  input  logic [XLEN-1:0] S2,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_res,
  input  logic            WB,
  input  logic [4:0]      Rd,
  input  logic [XLEN-1:0] reg_s,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [5:0]      id_op,
  output logic [5:0]      id_func,
  output logic [XLEN-1:0] id_a,
  output logic [XLEN-1:0] id_b,
  output logic [31:0]     id_imm,
  output logic [4:0]      id_rd,
  output logic            id_wen,
  output logic            id_load
);

  logic [5:0]      op;
  logic            is_store, use_rs2, stall;
  idex_t           dec, ctl_d, ctl_q;
  logic            valid_d, valid_q;
  logic [XLEN-1:0] op_a, op_b, a_d, a_q, b_d, b_q;

  assign op       = if_instr[OP_MSB:OP_LSB];
  assign Rs1      = if_instr[RS1_MSB:RS1_LSB];
  assign Rs2      = if_instr[RS2_MSB:RS2_LSB];
  assign is_store = op inside {OP_SB, OP_SH, OP_SW};
  assign use_rs2  = (op == OP_RTYPE) || is_store;

  always_comb begin
    dec    = '0;
    dec.pc = if_pc;
    dec.op = op;
    if (op == OP_RTYPE) begin
      dec.rd   = if_instr[RDR_MSB:RDR_LSB];
      dec.func = if_instr[FUNC_MSB:FUNC_LSB];
    end else if (op == OP_JAL) begin
      dec.rd = LINK_REG;
    end else begin
      dec.rd = if_instr[RDI_MSB:RDI_LSB];
    end
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: dec.imm = {16'h0, if_instr[IMM_MSB:0]};
      OP_LHI:                   dec.imm = {if_instr[IMM_MSB:0], 16'h0};
      OP_J, OP_JAL:             dec.imm = {{6{if_instr[JOFF_MSB]}}, if_instr[JOFF_MSB:0]};
      default:                  dec.imm = {{16{if_instr[IMM_MSB]}}, if_instr[IMM_MSB:0]};
    endcase
    dec.wen  = !(is_store || op inside {OP_BEQZ, OP_BNEZ, OP_J, OP_JR}) && dec.rd != 5'd0;
    dec.load = op >= OP_LD_LO && op <= OP_LD_HI;
  end

  dlx_hazard #(.XLEN(XLEN)) u_hazard (
    .rs1_i      (Rs1),
    .rs2_i      (Rs2),
    .use_rs2_i  (use_rs2),
    .s1_i       (S1),
    .s2_i       (S2),
    .mem_wen_i  (mem_wen),
    .mem_rd_i   (mem_rd),
    .mem_res_i  (mem_res),
    .wb_i       (WB),
    .wb_rd_i    (Rd),
    .wb_data_i  (reg_s),
    .id_valid_i (valid_q),
    .id_load_i  (ctl_q.load),
    .id_wen_i   (ctl_q.wen),
    .id_rd_i    (ctl_q.rd),
    .op_a_o     (op_a),
    .op_b_o     (op_b),
    .stall_o    (stall)
  );

  // Flush always accepts so fetch can move on; the instruction is simply dropped.
  assign id_ready = flush || (!stall && (!valid_q || ex_ready));

  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (if_valid && id_ready) begin
      valid_d = 1'b1;
      ctl_d   = dec;
      a_d     = op_a;
      b_d     = op_b;
    end else if (!valid_q || ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = ctl_q.pc;
  assign id_op    = ctl_q.op;
  assign id_func  = ctl_q.func;
  assign id_a     = a_q;
  assign id_b     = b_q;
  assign id_imm   = ctl_q.imm;
  assign id_rd    = ctl_q.rd;
  assign id_wen   = ctl_q.wen;
  assign id_load  = ctl_q.load;

endmodule

// File: tb/tb_dlx_decode.sv
// Scoreboard bench for dlx_decode: directed plan items plus randomized traffic against a reference model.
module tb_dlx_decode;

  logic        clk, rst_n, if_valid, id_ready, mem_wen, WB, flush, ex_ready;
  logic [31:0] if_instr, if_pc, S1, S2, mem_res, reg_s;
  logic [4:0]  Rs1, Rs2, mem_rd, Rd;
  logic        id_valid, id_wen, id_load;
  logic [31:0] id_pc, id_a, id_b, id_imm;
  logic [5:0]  id_op, id_func;
  logic [4:0]  id_rd;

  dlx_decode #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .Rs1(Rs1), .Rs2(Rs2), .S1(S1), .S2(S2),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_res(mem_res), .WB(WB), .Rd(Rd), .reg_s(reg_s),
    .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op),
    .id_func(id_func), .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_rd(id_rd),
    .id_wen(id_wen), .id_load(id_load)
  );

  typedef struct {
    bit [31:0] pc, a, b, imm;
    bit [5:0]  op, func;
    bit [4:0]  rd;
    bit        wen, load;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0, n_err = 0;

  // Model of what the ID/EX slot holds, only as far as hazards care.
  bit       m_v, m_wen, m_load;
  bit [4:0] m_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_dec(input bit [31:0] instr, input bit [31:0] pc);
    exp_t e;
    bit [5:0] op = instr[31:26];
    bit [15:0] lo = instr[15:0];
    e = '{default: 0};
    e.pc = pc;
    e.op = op;
    e.func = (op == 0) ? instr[5:0] : 6'd0;
    e.rd = (op == 0) ? instr[15:11] : (op == 6'h03) ? 5'd31 : instr[20:16];
    if (op inside {6'h0C, 6'h0D, 6'h0E}) e.imm = 32'(lo);
    else if (op == 6'h0F)                e.imm = 32'(lo) * 32'd65536;
    else if (op inside {6'h02, 6'h03})   e.imm = 32'($signed(instr[25:0]));
    else                                 e.imm = 32'($signed(lo));
    e.wen = !(op inside {6'h28, 6'h29, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h12}) && e.rd != 0;
    e.load = op >= 6'h20 && op <= 6'h25;
    return e;
  endfunction

  function automatic bit [31:0] model_opnd(input bit [4:0] r, input bit [31:0] rf);
    if (r == 0) return 0;
`ifdef DLX_FWD_EN
    if (mem_wen && mem_rd == r) return mem_res;
`endif
    if (WB && Rd == r) return reg_s;
    return rf;
  endfunction

  function automatic bit pending(input bit [4:0] r);
`ifdef DLX_FWD_EN
    return m_v && m_load && m_wen && m_rd == r;
`else
    return r != 0 && ((m_v && m_wen && m_rd == r) || (mem_wen && mem_rd == r));
`endif
  endfunction

  // Called at posedge+2: drive one cycle, check ready/addresses, predict, return at next posedge+2.
  task automatic step(input bit v, input bit [31:0] instr, input bit exr, input bit fl,
                      input bit mw, input bit [4:0] mrd, input bit [31:0] mres,
                      input bit wb, input bit [4:0] wrd, input bit [31:0] wdat,
                      input bit [31:0] s1, input bit [31:0] s2);
    bit [5:0] op = instr[31:26];
    bit use2, stl, rdy, acc;
    exp_t e;
    if_valid = v; if_instr = instr; if_pc = $urandom & 32'hFFFF_FFFC;
    ex_ready = exr; flush = fl; mem_wen = mw; mem_rd = mrd; mem_res = mres;
    WB = wb; Rd = wrd; reg_s = wdat; S1 = s1; S2 = s2;
    #1;
    check("Rs1", 64'(Rs1), 64'(instr[25:21]));
    check("Rs2", 64'(Rs2), 64'(instr[20:16]));
    use2 = (op == 0) || (op inside {6'h28, 6'h29, 6'h2B});
    stl = pending(instr[25:21]) || (use2 && pending(instr[20:16]));
    rdy = fl || (!stl && (!m_v || exr));
    check("id_ready", 64'(id_ready), 64'(rdy));
    acc = v && rdy && !fl;
    if (acc) begin
      e = model_dec(instr, if_pc);
      e.a = model_opnd(instr[25:21], s1);
      e.b = model_opnd(instr[20:16], s2);
      q.push_back(e);
      m_v = 1; m_rd = e.rd; m_wen = e.wen; m_load = e.load;
    end else if (fl || !m_v || exr) begin
      m_v = 0;
    end
    @(posedge clk); #2;
  endtask

  task automatic quiet(input bit [31:0] instr, input bit exr);
    step(1, instr, exr, 0, 0, 0, 0, 0, 0, 0, 32'h5, 32'h7);
  endtask

  task automatic chk_zero(input string nm);
    check(nm, {id_valid, id_wen, id_load, id_rd, id_op, id_func},  64'd0);
    check({nm, "_data"}, {id_pc, id_imm}, 64'd0);
    check({nm, "_opnd"}, {id_a, id_b}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk_zero("reset_zero");
    q.delete();
    m_v = 0;
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  // Monitor: a held instruction leaves ID/EX on ex_ready or flush at the coming edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (rst_n && id_valid && (ex_ready || flush)) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 64'(id_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check("pc", 64'(id_pc), 64'(e.pc));
          check("op", 64'(id_op), 64'(e.op));
          check("func", 64'(id_func), 64'(e.func));
          check("a", 64'(id_a), 64'(e.a));
          check("b", 64'(id_b), 64'(e.b));
          check("imm", 64'(id_imm), 64'(e.imm));
          check("rd", 64'(id_rd), 64'(e.rd));
          check("wen_load", {id_wen, id_load}, {e.wen, e.load});
        end
      end
    end
  end

  localparam bit [31:0] ADD_3_1_2 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam bit [31:0] LW_4      = {6'h23, 5'd0, 5'd4, 16'h0000};
  localparam bit [31:0] ADD_5_4_4 = {6'h00, 5'd4, 5'd4, 5'd5, 5'd0, 6'h20};
  localparam bit [31:0] ORI_2     = {6'h0D, 5'd0, 5'd2, 16'hFFFF};
  localparam bit [31:0] ADDI_2    = {6'h08, 5'd0, 5'd2, 16'hFFFF};
  localparam bit [31:0] JAL_NEG   = {6'h03, 26'h3FF_FFF0};
  localparam bit [31:0] LHI_7     = {6'h0F, 5'd0, 5'd7, 16'h1234};
  localparam bit [31:0] ADD_0_1_2 = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20};

  initial begin
    bit [5:0] ops [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                           6'h0F, 6'h12, 6'h20, 6'h23, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B};
    bit [31:0] ins;
    bit [4:0] keep_rd;
    bit [31:0] held_pc, held_a;
    rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; S1 = 0; S2 = 0;
    mem_wen = 0; mem_rd = 0; mem_res = 0; WB = 0; Rd = 0; reg_s = 0; flush = 0; ex_ready = 1;
    m_v = 0; m_rd = 0; m_wen = 0; m_load = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("por_zero");
    check("por_ready", 64'(id_ready), 64'd1);
    rst_n = 1;

    // Plain ADD, then WB bypass and MEM+WB on rs1.
    quiet(ADD_3_1_2, 1);
    step(1, ADD_3_1_2, 1, 0, 0, 0, 0, 1, 5'd1, 32'h11, 32'h5, 32'h7);
    step(1, ADD_3_1_2, 1, 0, 1, 5'd1, 32'h99, 1, 5'd1, 32'h11, 32'h5, 32'h7);
    step(1, ADD_3_1_2, 1, 0, 0, 0, 0, 0, 0, 0, 32'h5, 32'h7);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use: ADD retried until accepted, with the load result arriving from MEM.
    quiet(LW_4, 1);
    step(1, ADD_5_4_4, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h1);
    step(1, ADD_5_4_4, 1, 0, 1, 5'd4, 32'hABCD, 0, 0, 0, 32'h1, 32'h1);
    step(1, ADD_5_4_4, 1, 0, 0, 0, 0, 1, 5'd4, 32'hABCD, 32'h1, 32'h1);
    // Immediates and JAL link register.
    quiet(ORI_2, 1); quiet(ADDI_2, 1); quiet(JAL_NEG, 1); quiet(LHI_7, 1);
    quiet(ADD_0_1_2, 1);
    // Back-pressure: contents must not move while EX stalls.
    quiet(ADD_3_1_2, 1);
    held_pc = id_pc; held_a = id_a;
    for (int i = 0; i < 3; i++) begin
      step(1, ORI_2, 0, 0, 0, 0, 0, 1, 5'd1, 32'h77, 32'hF, 32'hF);
      check("hold_pc", 64'(id_pc), 64'(held_pc));
      check("hold_a", 64'(id_a), 64'(held_a));
      check("hold_valid", 64'(id_valid), 64'd1);
    end
    step(1, ORI_2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_kill", 64'(id_valid), 64'd0);
    // Reset mid-stream with something held.
    quiet(ADD_3_1_2, 0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 17)];
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      ins[15:11] = 5'($urandom_range(0, 3));
      keep_rd = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 4) != 0, ins, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 4) < 2, keep_rd, $urandom,
                $urandom_range(0, 4) < 2, 5'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
    end

    repeat (4) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
